// File: rtl/store_merge_ctrl.sv
// store_merge_ctrl: takes register data out to a word-only data memory.
// sw is written directly. sb/sh are read-modify-write: read the word, replace
// the addressed big-endian lane(s), then write the word back. busy stalls the
// pipeline until the store is committed or rejected.
module store_merge_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    output logic        busy,
    output logic        done,
    output logic        err_align,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_REQ,
        MERGE,
        WR_REQ,
        DONE
    } state_t;

    // The wait counter runs 0..TIMEOUT-1 while a request is outstanding
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [1:0]  op_type, op_type_next;
    logic [31:0] op_addr, op_addr_next;
    logic [31:0] op_data, op_data_next;
    logic [31:0] rd_word, rd_word_next;
    logic [7:0]  tmo_cnt, tmo_cnt_next;
    logic        busy_next;
    logic        done_next;
    logic        err_align_next;
    logic        err_timeout_next;
    logic        mem_req_next;
    logic        mem_we_next;
    logic [31:0] mem_addr_next;
    logic [31:0] mem_wdata_next;
    logic        illegal;
    logic [31:0] merged;

    // Reject misaligned halfword/word stores and the reserved type
    always_comb begin
        illegal = 1'b0;
        case (op_type)
            2'b01:   illegal = op_addr[0];
            2'b10:   illegal = (op_addr[1:0] != 2'b00);
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    // Replace the addressed big-endian lane(s) of the word read back from memory
    always_comb begin
        merged = rd_word;
        if (op_type == 2'b00) begin
            case (op_addr[1:0])
                2'd0:    merged[31:24] = op_data[7:0];
                2'd1:    merged[23:16] = op_data[7:0];
                2'd2:    merged[15:8]  = op_data[7:0];
                default: merged[7:0]   = op_data[7:0];
            endcase
        end else if (op_addr[1]) begin
            merged[15:0] = op_data[15:0];
        end else begin
            merged[31:16] = op_data[15:0];
        end
    end

    // Next-state and next registered-output values; everything holds by default except the done pulse
    always_comb begin
        state_next       = state;
        op_type_next     = op_type;
        op_addr_next     = op_addr;
        op_data_next     = op_data;
        rd_word_next     = rd_word;
        tmo_cnt_next     = tmo_cnt;
        busy_next        = busy;
        done_next        = 1'b0;
        err_align_next   = err_align;
        err_timeout_next = err_timeout;
        mem_req_next     = mem_req;
        mem_we_next      = mem_we;
        mem_addr_next    = mem_addr;
        mem_wdata_next   = mem_wdata;

        case (state)
            IDLE: begin
                if (start) begin
                    op_type_next = store_type;
                    op_addr_next = addr;
                    op_data_next = reg_data;
                    busy_next    = 1'b1;
                    state_next   = CHECK;
                end
            end
            CHECK: begin
                if (illegal) begin
                    err_align_next = 1'b1;
                    done_next      = 1'b1;
                    state_next     = DONE;
                end else begin
                    mem_addr_next = {op_addr[31:2], 2'b00};
                    mem_req_next  = 1'b1;
                    tmo_cnt_next  = 8'd0;
                    if (op_type == 2'b10) begin
                        mem_we_next    = 1'b1;
                        mem_wdata_next = op_data;
                        state_next     = WR_REQ;
                    end else begin
                        mem_we_next = 1'b0;
                        state_next  = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    rd_word_next = mem_rdata;
                    mem_req_next = 1'b0;
                    state_next   = MERGE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_timeout_next = 1'b1;
                    done_next        = 1'b1;
                    mem_req_next     = 1'b0;
                    state_next       = DONE;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'd1;
                end
            end
            MERGE: begin
                mem_wdata_next = merged;
                mem_we_next    = 1'b1;
                mem_req_next   = 1'b1;
                tmo_cnt_next   = 8'd0;
                state_next     = WR_REQ;
            end
            WR_REQ: begin
                if (mem_ack) begin
                    done_next    = 1'b1;
                    mem_req_next = 1'b0;
                    state_next   = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_timeout_next = 1'b1;
                    done_next        = 1'b1;
                    mem_req_next     = 1'b0;
                    state_next       = DONE;
                end else begin
                    tmo_cnt_next = tmo_cnt + 8'd1;
                end
            end
            DONE: begin
                busy_next        = 1'b0;
                err_align_next   = 1'b0;
                err_timeout_next = 1'b0;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, operand latches and all outputs are registered; reset drops any request at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_type     <= 2'b00;
            op_addr     <= 32'd0;
            op_data     <= 32'd0;
            rd_word     <= 32'd0;
            tmo_cnt     <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
        end else begin
            state       <= state_next;
            op_type     <= op_type_next;
            op_addr     <= op_addr_next;
            op_data     <= op_data_next;
            rd_word     <= rd_word_next;
            tmo_cnt     <= tmo_cnt_next;
            busy        <= busy_next;
            done        <= done_next;
            err_align   <= err_align_next;
            err_timeout <= err_timeout_next;
            mem_req     <= mem_req_next;
            mem_we      <= mem_we_next;
            mem_addr    <= mem_addr_next;
            mem_wdata   <= mem_wdata_next;
        end
    end

endmodule

// File: tb/tb_store_merge_ctrl.sv
// tb_store_merge_ctrl: directed and randomized stores against a behavioural
// memory that acks after a programmable delay, with a byte-level reference model.
module tb_store_merge_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] reg_data;
    logic        busy;
    logic        done;
    logic        err_align;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // memory model state
    logic [31:0] mem_word [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    int          ack_delay = 0;
    bit          ack_disable = 1'b0;
    bit          inject_ack = 1'b0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          n_reads = 0;
    int          n_writes = 0;
    int          unstable = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] hold_addr = 32'd0;
    logic [31:0] hold_wdata = 32'd0;
    logic        hold_we = 1'b0;

    always #5 clk = ~clk;

    store_merge_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .store_type(store_type),
        .addr(addr),
        .reg_data(reg_data),
        .busy(busy),
        .done(done),
        .err_align(err_align),
        .err_timeout(err_timeout),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    function automatic logic [31:0] dut_read(input logic [31:0] key);
        return mem_word.exists(key) ? mem_word[key] : 32'd0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] key);
        return ref_mem.exists(key) ? ref_mem[key] : 32'd0;
    endfunction

    // Store of 'size' bytes at byte offset 'off' of a big-endian word
    function automatic logic [31:0] ref_store(input logic [31:0] old, input int size,
                                              input int off, input logic [31:0] d);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = old[31-8*k -: 8];
        for (int i = 0; i < size; i++) b[off+i] = d[8*(size-1-i) +: 8];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Memory: acks ack_delay cycles after the request appears, logs traffic, checks stability
    always @(negedge clk) begin
        mem_ack = inject_ack;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (wait_cnt == 0) begin
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end else if (mem_addr !== hold_addr || mem_we !== hold_we ||
                         (mem_we && mem_wdata !== hold_wdata)) begin
                unstable++;
            end
            req_cycles++;
            if (!ack_disable && wait_cnt == ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem_word[{mem_addr[31:2], 2'b00}] = mem_wdata;
                    last_wr_addr = mem_addr;
                    n_writes++;
                end else begin
                    mem_rdata = dut_read({mem_addr[31:2], 2'b00});
                    n_reads++;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [31:0] key, input logic [31:0] w);
        mem_word[key] = w;
        ref_mem[key]  = w;
    endtask

    // Issue one start and wait (bounded) for done; latency counts the start cycle as 1
    task automatic apply_stimulus(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                  input bit poke, output int latency, output logic saw_align,
                                  output logic saw_tmo, output logic finished, output logic busy_ok);
        @(negedge clk);
        store_type = t;
        addr       = a;
        reg_data   = d;
        start      = 1'b1;
        latency    = 1;
        finished   = 1'b0;
        busy_ok    = 1'b1;
        saw_align  = 1'b0;
        saw_tmo    = 1'b0;
        for (int i = 0; i < 60 && !finished; i++) begin
            @(negedge clk);
            latency++;
            if (poke && latency == 3) begin
                start = 1'b1;
                addr  = a + 32'h20;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                finished  = 1'b1;
                saw_align = err_align;
                saw_tmo   = err_timeout;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [1:0] t, input logic [31:0] a,
                            input logic [31:0] d, input int delay, input bit no_ack, input bit poke);
        int          size, exp_lat, exp_reads, exp_writes, exp_req, lat;
        int          r0, w0, q0, u0;
        bit          exp_align, exp_tmo;
        logic [31:0] key;
        logic        saw_align, saw_tmo, fin, busy_ok;
        key       = {a[31:2], 2'b00};
        size      = 1 << t;
        exp_align = (t == 2'b11) || ((a % size) != 0);
        exp_tmo   = !exp_align && no_ack;
        if (exp_align) begin
            exp_lat = 3; exp_reads = 0; exp_writes = 0; exp_req = 0;
        end else if (no_ack) begin
            exp_lat = 2 + TMO + 1; exp_reads = 0; exp_writes = 0; exp_req = TMO;
        end else if (t == 2'b10) begin
            exp_lat = 2 + (delay + 1) + 1; exp_reads = 0; exp_writes = 1; exp_req = delay + 1;
        end else begin
            exp_lat = 2 + (delay + 1) + 1 + (delay + 1) + 1;
            exp_reads = 1; exp_writes = 1; exp_req = 2 * (delay + 1);
        end
        if (exp_writes != 0) ref_mem[key] = ref_store(ref_read(key), size, int'(a[1:0]), d);

        ack_delay   = delay;
        ack_disable = no_ack;
        r0 = n_reads; w0 = n_writes; q0 = req_cycles; u0 = unstable;
        apply_stimulus(t, a, d, poke, lat, saw_align, saw_tmo, fin, busy_ok);

        check_output({tag, "_done_seen"}, 32'(fin), 32'd1);
        check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_err_align"}, 32'(saw_align), 32'(exp_align));
        check_output({tag, "_err_timeout"}, 32'(saw_tmo), 32'(exp_tmo));
        check_output({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check_output({tag, "_req_cycles"}, 32'(req_cycles - q0), 32'(exp_req));
        check_output({tag, "_reads"}, 32'(n_reads - r0), 32'(exp_reads));
        check_output({tag, "_req_stable"}, 32'(unstable - u0), 32'd0);
        if (exp_writes != 0) check_output({tag, "_wr_addr"}, last_wr_addr, key);

        repeat (3) @(negedge clk);
        check_output({tag, "_writes"}, 32'(n_writes - w0), 32'(exp_writes));
        check_output({tag, "_word"}, dut_read(key), ref_read(key));
        check_output({tag, "_idle"}, {29'd0, busy, done, mem_req}, 32'd0);
        ack_disable = 1'b0;
    endtask

    initial begin
        logic        fin;
        int          w0;
        logic [1:0]  rt;
        logic [31:0] ra;

        rst_n      = 1'b0;
        start      = 1'b0;
        store_type = 2'b00;
        addr       = 32'd0;
        reg_data   = 32'd0;

        // reset state
        repeat (2) @(negedge clk);
        check_output("reset_flags", {26'd0, busy, done, err_align, err_timeout, mem_req, mem_we}, 32'd0);
        check_output("reset_mem_addr", mem_addr, 32'd0);
        check_output("reset_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed stores
        do_store("sw_aligned", 2'b10, 32'h0000_1008, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        check_output("sw_word_const", dut_read(32'h1008), 32'hDEADBEEF);

        preload(32'h2000, 32'h11223344);
        do_store("sb_off2", 2'b00, 32'h0000_2002, 32'h0000_00AB, 0, 1'b0, 1'b0);
        check_output("sb_word_const", dut_read(32'h2000), 32'h1122AB44);

        preload(32'h3000, 32'h11223344);
        do_store("sh_upper", 2'b01, 32'h0000_3000, 32'h0000_CAFE, 0, 1'b0, 1'b0);
        check_output("sh_upper_const", dut_read(32'h3000), 32'hCAFE3344);
        preload(32'h3000, 32'h11223344);
        do_store("sh_lower", 2'b01, 32'h0000_3002, 32'h0000_CAFE, 0, 1'b0, 1'b0);
        check_output("sh_lower_const", dut_read(32'h3000), 32'h1122CAFE);

        do_store("err_sh", 2'b01, 32'h0000_4001, 32'h1234_5678, 0, 1'b0, 1'b0);
        do_store("err_sw", 2'b10, 32'h0000_4002, 32'h1234_5678, 0, 1'b0, 1'b0);
        do_store("err_type", 2'b11, 32'h0000_4000, 32'h1234_5678, 0, 1'b0, 1'b0);

        do_store("timeout_sb", 2'b00, 32'h0000_2001, 32'h0000_0055, 0, 1'b1, 1'b0);
        do_store("timeout_sw", 2'b10, 32'h0000_2004, 32'h0BAD_F00D, 0, 1'b1, 1'b0);
        do_store("ack_at_limit", 2'b00, 32'h0000_2003, 32'h0000_0077, TMO - 1, 1'b0, 1'b0);

        // async reset while a write request is outstanding
        ack_disable = 1'b1;
        w0 = n_writes;
        @(negedge clk);
        store_type = 2'b10;
        addr       = 32'h0000_5000;
        reg_data   = 32'h5555_AAAA;
        start      = 1'b1;
        fin        = 1'b0;
        for (int i = 0; i < 10 && !fin; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_req) fin = 1'b1;
        end
        check_output("rst_reached_wr", 32'(fin), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_async_drop", {29'd0, mem_req, busy, done}, 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        ack_disable = 1'b0;
        @(posedge clk);
        #1 inject_ack = 1'b1;
        @(posedge clk);
        #1 inject_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_output("late_ack_ignored", {30'd0, busy, mem_req}, 32'd0);
        check_output("rst_no_write", 32'(n_writes - w0), 32'd0);
        check_output("rst_word_kept", dut_read(32'h5000), ref_read(32'h5000));

        // normal store after reset, with a start pulsed while busy
        do_store("post_rst_sw", 2'b10, 32'h0000_0010, 32'hA5A5_0F0F, 0, 1'b0, 1'b1);
        check_output("busy_start_ignored", dut_read(32'h0030), ref_read(32'h0030));

        // randomized stores over a small preloaded region
        for (int i = 0; i < 16; i++) preload(32'h100 + 32'(4 * i), $urandom);
        for (int n = 0; n < 40; n++) begin
            rt = 2'($urandom_range(0, 3));
            ra = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            do_store($sformatf("rnd%0d", n), rt, ra, $urandom, int'($urandom_range(0, TMO - 1)),
                     1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
